word_serializer: RTL

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_pkg.sv | 18 +
 rtl/word_serializer_sync_fifo.sv | 60 ++++++
 rtl/word_serializer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer and its FIFO.
// State encodings and default geometry live here so both files agree.
package word_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_serializer_sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on pop_data while count > 0.
// Pushes to a full FIFO and pops from an empty FIFO are ignored.
module sync_fifo
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the current occupancy.
    always_comb begin
        push_ok_s = push && (count_r < FULL_CNT) && !sys_rst;
        pop_ok_s  = pop && (count_r != {(AW+1){1'b0}}) && !sys_rst;
        pop_data  = mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            else           wr_ptr_r <= wr_ptr_r;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            else           rd_ptr_r <= rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge sys_clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: words queue in a FIFO and are shifted out one bit
// per ser_en strobe, with back-to-back words sent without a gap bit.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     ser_en,
    output logic                     out,
    output logic                     out_valid,
    output logic                     word_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int CW = cnt_width(WIDTH);
    localparam int FW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(WIDTH - 1);
    localparam logic [FW-1:0] DEPTH_CNT = FW'(DEPTH);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] shifter_r;
    logic [WIDTH-1:0] head_data_s;
    logic [CW-1:0]    bit_cnt_r;
    logic [FW-1:0]    count_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_has_s;
    logic             last_bit_s;
    logic             cur_bit_s;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (in_data),
        .pop_data  (head_data_s),
        .count     (count_s)
    );

    // Handshake and pop decision; in_ready ignores a same-cycle pop on purpose.
    always_comb begin
        in_ready   = (count_s < DEPTH_CNT) && !sys_rst;
        push_s     = in_valid && in_ready;
        fifo_has_s = (count_s != {FW{1'b0}});
        last_bit_s = (state_r == ST_SHIFT) && ser_en && (bit_cnt_r == {CW{1'b0}});
        fifo_count = count_s;
        if (sys_rst)                 pop_s = 1'b0;
        else if (state_r == ST_IDLE) pop_s = fifo_has_s;
        else                         pop_s = last_bit_s && fifo_has_s;
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_r <= ST_IDLE;
        else         state_r <= state_next_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (fifo_has_s) state_next_s = ST_SHIFT;
                else            state_next_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (last_bit_s && !fifo_has_s) state_next_s = ST_IDLE;
                else                           state_next_s = ST_SHIFT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Shifter and bit counter; a pop reloads both on the same edge as the last bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shifter_r <= {WIDTH{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else if (pop_s) begin
            shifter_r <= head_data_s;
            bit_cnt_r <= LAST_IDX;
        end else if ((state_r == ST_SHIFT) && ser_en && (bit_cnt_r != {CW{1'b0}})) begin
            shifter_r <= MSB_FIRST ? (shifter_r << 1'b1) : (shifter_r >> 1'b1);
            bit_cnt_r <= bit_cnt_r - CW'(1);
        end else begin
            shifter_r <= shifter_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Output decode, forced quiet during reset.
    always_comb begin
        out_valid = 1'b0;
        out       = 1'b0;
        word_done = 1'b0;
        if (MSB_FIRST) cur_bit_s = shifter_r[WIDTH-1];
        else           cur_bit_s = shifter_r[0];
        if (!sys_rst && (state_r == ST_SHIFT)) begin
            out_valid = 1'b1;
            out       = cur_bit_s;
            word_done = last_bit_s;
        end else begin
            out_valid = 1'b0;
            out       = 1'b0;
            word_done = 1'b0;
        end
    end

endmodule
